// File: rtl/valve_demux_if.sv
// ---------------------------------------------------------------------------
// valve_demux_if
// Command channel between the flow-control sequencer and the valve
// demultiplexer.
//   cmd_valid      : command present (sequencer -> demux)
//   cmd_ready      : demux can take a command (demux -> sequencer)
//   cmd_sel        : target channel index
//   cmd_level      : drive level for the target (0 closes everything)
//   cmd_mode       : 0 = latch, 1 = pulse
//   cmd_pulse_len  : pulse length in cycles, used in pulse mode only
// Modports: master = command source, slave = valve_demux.
// ---------------------------------------------------------------------------
interface valve_demux_if #(
    parameter int SEL_W   = 4,
    parameter int PULSE_W = 16
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [SEL_W-1:0]   cmd_sel;
    logic               cmd_level;
    logic               cmd_mode;
    logic [PULSE_W-1:0] cmd_pulse_len;

    modport master (
        output cmd_valid,
        output cmd_sel,
        output cmd_level,
        output cmd_mode,
        output cmd_pulse_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_sel,
        input  cmd_level,
        input  cmd_mode,
        input  cmd_pulse_len,
        output cmd_ready
    );
endinterface

// File: rtl/valve_demux.sv
// ---------------------------------------------------------------------------
// valve_demux
// Registered 1-to-NUM_CH valve demultiplexer with break-before-make.
// Every accepted command with a valid select first forces all outputs low
// for DEAD_CYCLES cycles, then drives the selected channel either latched
// (until the next command or enable drop) or for a counted pulse.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   enable     : global drive enable, low closes all valves and aborts
//   cmd        : command channel (valve_demux_if.slave)
//   out        : registered valve drive, one-hot or zero
//   active_ch  : index of the last channel applied
//   busy       : high while in dead time or pulse
//   err        : one-cycle flag for a rejected out-of-range select
// ---------------------------------------------------------------------------
module valve_demux #(
    parameter int NUM_CH      = 16,
    parameter int SEL_W       = 4,
    parameter int DEAD_CYCLES = 8,
    parameter int PULSE_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    valve_demux_if.slave      cmd,
    output logic [NUM_CH-1:0] out,
    output logic [SEL_W-1:0]  active_ch,
    output logic              busy,
    output logic              err
);

    // Counter only needs to hold DEAD_CYCLES-1.
    localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEAD  = 2'd1,
        ST_PULSE = 2'd2
    } state_t;

    state_t             state_r;
    logic [DEAD_W-1:0]  dead_cnt_r;
    logic [PULSE_W-1:0] pulse_cnt_r;
    logic [SEL_W-1:0]   sel_r;
    logic               level_r;
    logic               mode_r;
    logic [PULSE_W-1:0] len_r;

    logic               accept_s;
    logic               sel_ok_s;
    logic [NUM_CH-1:0]  onehot_s;
    logic [PULSE_W-1:0] pulse_load_s;

    // Ready is combinational so a rejected command costs only one cycle.
    always_comb begin
        cmd.cmd_ready = (state_r == ST_IDLE) && enable && !rst;
        accept_s      = cmd.cmd_valid && cmd.cmd_ready;
        sel_ok_s      = (32'(cmd.cmd_sel) < 32'(NUM_CH));
    end

    // Decode of the captured select into the drive pattern.
    always_comb begin
        onehot_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_r == SEL_W'(i)) begin
                onehot_s[i] = level_r;
            end else begin
                onehot_s[i] = 1'b0;
            end
        end
    end

    // A zero length still yields a one-cycle pulse; the counter never wraps.
    always_comb begin
        if (len_r == {PULSE_W{1'b0}}) begin
            pulse_load_s = {PULSE_W{1'b0}};
        end else begin
            pulse_load_s = len_r - {{(PULSE_W-1){1'b0}}, 1'b1};
        end
    end

    // Control FSM with registered valve drive and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            out         <= {NUM_CH{1'b0}};
            active_ch   <= {SEL_W{1'b0}};
            busy        <= 1'b0;
            err         <= 1'b0;
            dead_cnt_r  <= {DEAD_W{1'b0}};
            pulse_cnt_r <= {PULSE_W{1'b0}};
            sel_r       <= {SEL_W{1'b0}};
            level_r     <= 1'b0;
            mode_r      <= 1'b0;
            len_r       <= {PULSE_W{1'b0}};
        end else if (!enable) begin
            // Abort: close everything and drop any in-flight command.
            state_r <= ST_IDLE;
            out     <= {NUM_CH{1'b0}};
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && !sel_ok_s) begin
                        err <= 1'b1;
                    end else if (accept_s) begin
                        out        <= {NUM_CH{1'b0}};
                        sel_r      <= cmd.cmd_sel;
                        level_r    <= cmd.cmd_level;
                        mode_r     <= cmd.cmd_mode;
                        len_r      <= cmd.cmd_pulse_len;
                        dead_cnt_r <= DEAD_W'(DEAD_CYCLES - 1);
                        busy       <= 1'b1;
                        state_r    <= ST_DEAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt_r != {DEAD_W{1'b0}}) begin
                        dead_cnt_r <= dead_cnt_r - {{(DEAD_W-1){1'b0}}, 1'b1};
                    end else begin
                        out       <= onehot_s;
                        active_ch <= sel_r;
                        if (mode_r) begin
                            pulse_cnt_r <= pulse_load_s;
                            state_r     <= ST_PULSE;
                        end else begin
                            busy    <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_PULSE: begin
                    if (pulse_cnt_r != {PULSE_W{1'b0}}) begin
                        pulse_cnt_r <= pulse_cnt_r - {{(PULSE_W-1){1'b0}}, 1'b1};
                    end else begin
                        out     <= {NUM_CH{1'b0}};
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    out     <= {NUM_CH{1'b0}};
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
